// File: rtl/magnitude_para_c2_serial_pkg.sv
// rtl/magnitude_para_c2_serial_pkg.sv - shared constants for the serial sign-magnitude to two's-complement converter
// Contents: FSM state encoding and the default data width.
package magnitude_para_c2_serial_pkg;

  localparam int DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/magnitude_para_c2_serial_if.sv
// rtl/magnitude_para_c2_serial_if.sv - start/ready/valid bus of the serial converter
// Signals:
//   start    request a conversion (requester -> converter)
//   mag      unsigned magnitude, WIDTH bits (requester -> converter)
//   SINAL    sign, 1 = negative (requester -> converter)
//   ready    converter can accept start (converter -> requester)
//   valid    one-cycle pulse, out/overflow are new (converter -> requester)
//   out      two's-complement result, WIDTH bits (converter -> requester)
//   overflow result not representable in WIDTH bits (converter -> requester)
interface magnitude_para_c2_serial_if
  import magnitude_para_c2_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] mag;
  logic             SINAL;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] out;
  logic             overflow;

  modport master (
    output start, mag, SINAL,
    input  ready, valid, out, overflow
  );

  modport slave (
    input  start, mag, SINAL,
    output ready, valid, out, overflow
  );

endinterface

// File: rtl/magnitude_para_c2_serial_somador1bit.sv
// rtl/magnitude_para_c2_serial_somador1bit.sv - 1-bit full adder
// Ports:
//   a, b  operand bits
//   cin   carry in
//   s     sum
//   cout  carry out
module somador1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/magnitude_para_c2_serial.sv
// rtl/magnitude_para_c2_serial.sv - bit-serial sign-magnitude to two's-complement converter
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of magnitude_para_c2_serial_if (start/mag/SINAL in,
//          ready/valid/out/overflow out)
// One full-adder step per clock in CONV, result registered on leaving DONE,
// valid pulses the cycle after that with ready still held low.
module magnitude_para_c2_serial
  import magnitude_para_c2_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  magnitude_para_c2_serial_if.slave   bus
);

  localparam int IW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mag_l;
  logic             sinal_l;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] out_r;
  logic             ovf_r;
  logic             valid_r;

  logic ready_c;
  logic a_bit;
  logic sum_bit;
  logic carry_nxt;
  logic last_bit;
  logic ovf_c;

  // Ones' complement of the current bit when negative; the +1 enters as the
  // initial carry, so -mag = ~mag + 1 is formed one bit at a time.
  assign a_bit    = mag_l[idx] ^ sinal_l;
  assign last_bit = (idx == IW'(WIDTH - 1));

  somador1bit u_fa (
    .a    (1'b0),
    .b    (a_bit),
    .cin  (carry),
    .s    (sum_bit),
    .cout (carry_nxt)
  );

  // Positive values need the MSB clear; negative values may reach -2^(WIDTH-1).
  assign ovf_c = sinal_l ? (mag_l > {1'b1, {(WIDTH-1){1'b0}}}) : mag_l[WIDTH-1];

  // valid_r is high in the first IDLE cycle; keeping ready low there stops a
  // new start from being taken alongside the result pulse.
  assign ready_c      = (state == IDLE) && !valid_r;
  assign bus.ready    = ready_c;
  assign bus.valid    = valid_r;
  assign bus.out      = out_r;
  assign bus.overflow = ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && ready_c) state_nxt = CONV;
      CONV:    if (last_bit)             state_nxt = DONE;
      DONE:                              state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_l   <= '0;
      sinal_l <= 1'b0;
      carry   <= 1'b0;
      idx     <= '0;
      shreg   <= '0;
      out_r   <= '0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && ready_c) begin
            mag_l   <= bus.mag;
            sinal_l <= bus.SINAL;
            carry   <= bus.SINAL;
            idx     <= '0;
            shreg   <= '0;
          end
        end
        CONV: begin
          // LSB-first fill: after WIDTH shifts bit 0 has reached position 0.
          shreg <= {sum_bit, shreg[WIDTH-1:1]};
          carry <= carry_nxt;
          idx   <= last_bit ? '0 : idx + 1'b1;
        end
        DONE: begin
          out_r   <= shreg;
          ovf_r   <= ovf_c;
          valid_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_magnitude_para_c2_serial.sv
// tb/tb_magnitude_para_c2_serial.sv - self-checking bench for magnitude_para_c2_serial
module tb_magnitude_para_c2_serial;

  localparam int W = 6;

  logic clk = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  magnitude_para_c2_serial_if #(.WIDTH(W)) bus ();

  magnitude_para_c2_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_out(input int m, input bit s);
    int v;
    v = s ? -m : m;
    return W'(v & ((1 << W) - 1));
  endfunction

  function automatic logic model_ovf(input int m, input bit s);
    if (s) return (m > (1 << (W - 1)));
    return (m >= (1 << (W - 1)));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one conversion starting at a negedge; returns at the negedge after valid.
  task automatic convert(input int m, input bit s, input bit disturb);
    int  cyc;
    int  guard;
    bit  seen;
    logic [W-1:0] exp_out;
    logic         exp_ovf;
    exp_out = model_out(m, s);
    exp_ovf = model_ovf(m, s);
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_start", 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.mag   = W'(m);
    bus.SINAL = s;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("ready_low_in_conv", 32'(bus.ready), 32'd0);
      if (bus.valid === 1'b1) seen = 1;
      if (disturb && cyc == 3) begin
        bus.mag   = ~W'(m);
        bus.SINAL = ~s;
        bus.start = 1'b1;
      end
      if (disturb && cyc == 4) bus.start = 1'b0;
    end
    check("valid_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'd8);
    check("out", 32'(bus.out), 32'(exp_out));
    check("overflow", 32'(bus.overflow), 32'(exp_ovf));
    check("ready_low_with_valid", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check("valid_one_cycle", 32'(bus.valid), 32'd0);
    check("ready_returns", 32'(bus.ready), 32'd1);
    check("out_holds", 32'(bus.out), 32'(exp_out));
  endtask

  initial begin
    int vcount;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.mag   = '0;
    bus.SINAL = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    convert(5, 1'b1, 1'b0);
    convert(31, 1'b0, 1'b0);
    convert(32, 1'b0, 1'b0);
    convert(32, 1'b1, 1'b0);
    convert(33, 1'b1, 1'b0);
    convert(0, 1'b1, 1'b0);
    convert(5, 1'b1, 1'b1);
    // the disturbing start pulse must not have launched another conversion
    vcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.valid === 1'b1) vcount++;
    end
    check("no_extra_valid", 32'(vcount), 32'd0);

    // back-to-back: second start issued the cycle ready returns
    convert(20, 1'b0, 1'b0);
    convert(1, 1'b1, 1'b0);

    // reset in the third CONV cycle
    bus.start = 1'b1;
    bus.mag   = W'(9);
    bus.SINAL = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(bus.out), 32'd0);
    check("midrst_overflow", 32'(bus.overflow), 32'd0);
    check("midrst_valid", 32'(bus.valid), 32'd0);
    check("midrst_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.valid === 1'b1) vcount++;
    end
    check("midrst_no_valid", 32'(vcount), 32'd0);
    check("midrst_ready_after", 32'(bus.ready), 32'd1);

    convert(7, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      convert(int'($urandom_range(0, (1 << W) - 1)), bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
